text_console_ctrl: RTL and testbench

//  Sequences writes into the GPU 80x30 ASCII text RAM on behalf of the CPU. It turns a byte stream into

---
 rtl/text_console_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
// Text console write sequencer: turns CPU bytes into cursor-tracked writes to an 80x30 text RAM.
// Latency: a printable byte is written one cycle after it is accepted. A clear issues one write per cycle.
// Backpressure: char_ready is high only in IDLE. A byte offered while busy is dropped, so the CPU polls busy.
// Optional macro TEXT_CONSOLE_TAB_EN adds tab expansion to the next multiple of 8 columns.
module text_console_ctrl #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        busy,
  output logic [11:0] ram_w_addr,
  output logic [7:0]  ram_w_data,
  output logic        ram_w_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUT  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  localparam logic [1:0] MD_CHAR = 2'd0;
  localparam logic [1:0] MD_BS   = 2'd1;
`ifdef TEXT_CONSOLE_TAB_EN
  localparam logic [1:0] MD_TAB  = 2'd2;
`endif

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  logic [1:0]  state;
  logic [1:0]  put_mode;
  logic [6:0]  work_col;   // column being written while in PUT
  logic [11:0] row_base;   // row*COLS of the row the cursor is on (or entering)
  logic [11:0] fill_end;   // last address of the current fill
  logic [4:0]  pend_row;   // cursor row to publish when the fill finishes

  logic [4:0]  nl_row;
  logic [11:0] nl_base;
  logic [11:0] cur_addr;
  logic [6:0]  next_col;
  logic        accept;

  // Newline target row/base computed incrementally so no multiplier is needed
  always_comb begin
    nl_row   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    nl_base  = (cursor_row == LAST_ROW) ? 12'd0 : row_base + COLS_W;
    cur_addr = row_base + {5'd0, cursor_col};
    next_col = work_col + 7'd1;
    accept   = char_valid && char_ready;
  end

  // Main sequencer: byte decode, single writes, tab expansion and fills
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      put_mode   <= MD_CHAR;
      work_col   <= 7'd0;
      row_base   <= 12'd0;
      fill_end   <= 12'd0;
      pend_row   <= 5'd0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
      ram_w_addr <= 12'd0;
      ram_w_data <= FILL_CHAR;
      ram_w_en   <= 1'b0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
              ram_w_en   <= 1'b1;
              ram_w_addr <= cur_addr;
              ram_w_data <= char_in;
              work_col   <= cursor_col;
              put_mode   <= MD_CHAR;
              state      <= ST_PUT;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (char_in == 8'h0D) begin
              cursor_col <= 7'd0;
            end else if (char_in == 8'h0A) begin
              row_base   <= nl_base;
              ram_w_addr <= nl_base;
              fill_end   <= nl_base + COLS_W - 12'd1;
              pend_row   <= nl_row;
              ram_w_data <= FILL_CHAR;
              ram_w_en   <= 1'b1;
              state      <= ST_FILL;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (char_in == 8'h08) begin
              // Backspace at column 0 is a no-op and keeps the block ready
              if (cursor_col != 7'd0) begin
                ram_w_en   <= 1'b1;
                ram_w_addr <= cur_addr - 12'd1;
                ram_w_data <= FILL_CHAR;
                work_col   <= cursor_col - 7'd1;
                put_mode   <= MD_BS;
                state      <= ST_PUT;
                char_ready <= 1'b0;
                busy       <= 1'b1;
              end
            end else if (char_in == 8'h0C) begin
              row_base   <= 12'd0;
              ram_w_addr <= 12'd0;
              fill_end   <= LAST_ADDR;
              pend_row   <= 5'd0;
              ram_w_data <= FILL_CHAR;
              ram_w_en   <= 1'b1;
              state      <= ST_FILL;
              char_ready <= 1'b0;
              busy       <= 1'b1;
`ifdef TEXT_CONSOLE_TAB_EN
            end else if (char_in == 8'h09) begin
              ram_w_en   <= 1'b1;
              ram_w_addr <= cur_addr;
              ram_w_data <= FILL_CHAR;
              work_col   <= cursor_col;
              put_mode   <= MD_TAB;
              state      <= ST_PUT;
              char_ready <= 1'b0;
              busy       <= 1'b1;
`endif
            end
          end
        end

        ST_PUT: begin
          if (put_mode == MD_BS) begin
            ram_w_en   <= 1'b0;
            cursor_col <= work_col;
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else if (work_col == LAST_COL) begin
            // Wrapped past the last column: enter the next row and clear it
            row_base   <= nl_base;
            ram_w_addr <= nl_base;
            fill_end   <= nl_base + COLS_W - 12'd1;
            pend_row   <= nl_row;
            ram_w_data <= FILL_CHAR;
            ram_w_en   <= 1'b1;
            state      <= ST_FILL;
`ifdef TEXT_CONSOLE_TAB_EN
          end else if (put_mode == MD_TAB && next_col[2:0] != 3'd0) begin
            ram_w_addr <= ram_w_addr + 12'd1;
            work_col   <= next_col;
`endif
          end else begin
            ram_w_en   <= 1'b0;
            cursor_col <= next_col;
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end

        ST_FILL: begin
          if (ram_w_addr == fill_end) begin
            ram_w_en   <= 1'b0;
            cursor_col <= 7'd0;
            cursor_row <= pend_row;
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            ram_w_addr <= ram_w_addr + 12'd1;
          end
        end

        default: begin
          ram_w_en   <= 1'b0;
          state      <= ST_IDLE;
          char_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: prints, CR/LF/BS, wrap clears, form feed and reset mid-fill.
// Writes are captured on the falling edge into address/data queues for checking.
// Every comparison goes through chk; one summary line ends the run.
module tb_text_console_ctrl;

  localparam int LIMIT = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        busy;
  logic [11:0] ram_w_addr;
  logic [7:0]  ram_w_data;
  logic        ram_w_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int errors = 0;

  logic [11:0] wa[$];
  logic [7:0]  wd[$];

  int          last_busy;
  logic        n1_en;
  logic [11:0] n1_addr;
  logic [7:0]  n1_data;

  text_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_w_en   (ram_w_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  // Capture every RAM write away from the active edge
  always @(negedge clk) begin
    if (!rst && ram_w_en) begin
      wa.push_back(ram_w_addr);
      wd.push_back(ram_w_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Offer one byte, then wait for ready; records the N+1 write and busy length
  task automatic send(input logic [7:0] b, input bit hold);
    int t;
    t = 0;
    while (!char_ready && t < LIMIT) begin
      @(posedge clk); #1; t++;
    end
    if (t >= LIMIT) chk("ready_timeout", char_ready, 1);
    wa.delete();
    wd.delete();
    char_in    = b;
    char_valid = 1'b1;
    @(posedge clk); #1;
    n1_en   = ram_w_en;
    n1_addr = ram_w_addr;
    n1_data = ram_w_data;
    char_valid = hold;
    char_in    = 8'h58;
    last_busy  = 0;
    while (!char_ready && last_busy < LIMIT) begin
      last_busy++;
      @(posedge clk); #1;
    end
    char_valid = 1'b0;
    if (last_busy >= LIMIT) chk("busy_timeout", char_ready, 1);
  endtask

  task automatic put_n(input int n);
    for (int i = 0; i < n; i++) send(8'h62, 1'b0);
  endtask

  task automatic lf_n(input int n);
    for (int i = 0; i < n; i++) send(8'h0A, 1'b0);
  endtask

  initial begin
    int bad;
    #12;
    // Reset values
    chk("rst_ready", char_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", ram_w_en, 0);
    chk("rst_addr", ram_w_addr, 0);
    chk("rst_data", ram_w_data, 8'h20);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 'A' at (0,0)
    send(8'h41, 1'b0);
    chk("a_en_n1", n1_en, 1);
    chk("a_addr", n1_addr, 0);
    chk("a_data", n1_data, 8'h41);
    chk("a_busy", last_busy, 1);
    chk("a_nwr", wa.size(), 1);
    chk("a_col", cursor_col, 1);
    chk("a_row", cursor_row, 0);

    // CR: no write, ready next cycle
    send(8'h0D, 1'b0);
    chk("cr_nwr", wa.size(), 0);
    chk("cr_busy", last_busy, 0);
    chk("cr_col", cursor_col, 0);

    // LF from row 0 clears row 1
    send(8'h0A, 1'b0);
    chk("lf_nwr", wa.size(), 80);
    chk("lf_first", wa[0], 80);
    chk("lf_last", wa[79], 159);
    chk("lf_busy", last_busy, 80);
    chk("lf_row", cursor_row, 1);

    // Move to (79,2) then print 'Z' to wrap
    lf_n(1);
    put_n(79);
    chk("pre_z_col", cursor_col, 79);
    chk("pre_z_row", cursor_row, 2);
    send(8'h5A, 1'b0);
    chk("z_addr", n1_addr, 239);
    chk("z_data", n1_data, 8'h5A);
    chk("z_nwr", wa.size(), 81);
    chk("z_clr_first", wa[1], 240);
    chk("z_clr_last", wa[80], 319);
    chk("z_clr_data", wd[80], 8'h20);
    chk("z_busy", last_busy, 81);
    chk("z_col", cursor_col, 0);
    chk("z_row", cursor_row, 3);

    // Move to (5,29) then LF wraps to row 0
    lf_n(26);
    put_n(5);
    chk("pre_wrap_row", cursor_row, 29);
    send(8'h0A, 1'b0);
    chk("wrap_nwr", wa.size(), 80);
    chk("wrap_first", wa[0], 0);
    chk("wrap_last", wa[79], 79);
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 0);

    // BS at column 0 is a no-op; at column 3 it clears column 2
    lf_n(4);
    send(8'h08, 1'b0);
    chk("bs0_nwr", wa.size(), 0);
    chk("bs0_col", cursor_col, 0);
    chk("bs0_row", cursor_row, 4);
    put_n(3);
    send(8'h08, 1'b0);
    chk("bs_nwr", wa.size(), 1);
    chk("bs_addr", n1_addr, 322);
    chk("bs_data", n1_data, 8'h20);
    chk("bs_col", cursor_col, 2);
    chk("bs_row", cursor_row, 4);

    // Unknown control byte is swallowed
    send(8'h01, 1'b0);
    chk("unk_nwr", wa.size(), 0);
    chk("unk_busy", last_busy, 0);
    chk("unk_col", cursor_col, 2);

`ifndef TEXT_CONSOLE_TAB_EN
    send(8'h09, 1'b0);
    chk("tab_off_nwr", wa.size(), 0);
    chk("tab_off_col", cursor_col, 2);
`endif

    // Form feed with char_valid held high throughout
    send(8'h0C, 1'b1);
    chk("ff_nwr", wa.size(), 2400);
    chk("ff_busy", last_busy, 2400);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != 12'(i) || wd[i] != 8'h20) bad++;
    chk("ff_seq", bad, 0);
    chk("ff_col", cursor_col, 0);
    chk("ff_row", cursor_row, 0);
    @(posedge clk); #1;
    chk("ff_noaccept", wa.size(), 2400);

    // Reset during form feed at write 1000 (address 999)
    put_n(2);
    char_in    = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    for (int i = 0; i < 999; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_en", ram_w_en, 1);
    chk("mid_addr", ram_w_addr, 999);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", ram_w_en, 0);
    chk("arst_ready", char_ready, 1);
    chk("arst_col", cursor_col, 0);
    chk("arst_row", cursor_row, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef TEXT_CONSOLE_TAB_EN
    put_n(3);
    send(8'h09, 1'b0);
    chk("tab_nwr", wa.size(), 5);
    chk("tab_first", wa[0], 3);
    chk("tab_last", wa[4], 7);
    chk("tab_busy", last_busy, 5);
    chk("tab_col", cursor_col, 8);
    chk("tab_row", cursor_row, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
